// File: rtl/snake_pkg.sv
// Shared constants and state encoding for the snake target placement logic.
// Screen geometry, segment store sizing and the placement FSM states.
package snake_pkg;

    localparam int H_LIMIT   = 160;
    localparam int V_LIMIT   = 120;
    localparam int H_DEFAULT = 80;
    localparam int V_DEFAULT = 60;
    localparam int MAX_LEN   = 32;
    localparam int MAX_TRIES = 8;

    localparam int H_W       = 8;
    localparam int V_W       = 7;
    localparam int SEG_IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W     = SEG_IDX_W + 1;
    localparam int TRY_W     = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        RANGE  = 3'd2,
        READ   = 3'd3,
        CMP    = 3'd4,
        REJECT = 3'd5,
        COMMIT = 3'd6
    } state_t;

    // Lengths beyond the segment store size are treated as a full store.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/target_placement_ctrl.sv
// Places a new snake target: samples the random generator, rejects off-screen or
// body-occupied candidates, retries a bounded number of times, then commits.
module target_placement_ctrl
    import snake_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 TARGET_REACHED,
    input  logic [H_W-1:0]       RAND_H,
    input  logic [V_W-1:0]       RAND_V,
    input  logic [LEN_W-1:0]     SNAKE_LENGTH,
    output logic [SEG_IDX_W-1:0] SEG_RD_ADDR,
    input  logic [H_W-1:0]       SEG_H,
    input  logic [V_W-1:0]       SEG_V,
    output logic [H_W-1:0]       TARGET_ADDR_H,
    output logic [V_W-1:0]       TARGET_ADDR_V,
    output logic                 TARGET_VALID,
    output logic                 BUSY,
    output logic                 PLACED
);

    state_t                 state_reg, state_next;
    logic [H_W-1:0]         cand_h_reg, cand_h_next;
    logic [V_W-1:0]         cand_v_reg, cand_v_next;
    logic [LEN_W-1:0]       len_reg, len_next;
    logic [TRY_W-1:0]       try_reg, try_next;
    logic [SEG_IDX_W-1:0]   idx_reg, idx_next;
    logic [H_W-1:0]         tgt_h_reg, tgt_h_next;
    logic [V_W-1:0]         tgt_v_reg, tgt_v_next;
    logic                   valid_reg, valid_next;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg  <= IDLE;
            cand_h_reg <= H_W'(H_DEFAULT);
            cand_v_reg <= V_W'(V_DEFAULT);
            len_reg    <= '0;
            try_reg    <= '0;
            idx_reg    <= '0;
            tgt_h_reg  <= H_W'(H_DEFAULT);
            tgt_v_reg  <= V_W'(V_DEFAULT);
            valid_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cand_h_reg <= cand_h_next;
            cand_v_reg <= cand_v_next;
            len_reg    <= len_next;
            try_reg    <= try_next;
            idx_reg    <= idx_next;
            tgt_h_reg  <= tgt_h_next;
            tgt_v_reg  <= tgt_v_next;
            valid_reg  <= valid_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cand_h_next = cand_h_reg;
        cand_v_next = cand_v_reg;
        len_next    = len_reg;
        try_next    = try_reg;
        idx_next    = idx_reg;
        tgt_h_next  = tgt_h_reg;
        tgt_v_next  = tgt_v_reg;
        valid_next  = valid_reg;

        case (state_reg)
            IDLE: begin
                if (TARGET_REACHED) begin
                    valid_next = 1'b0;
                    try_next   = '0;
                    len_next   = clamp_len(SNAKE_LENGTH);
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                cand_h_next = RAND_H;
                cand_v_next = RAND_V;
                if (try_reg < TRY_W'(MAX_TRIES)) begin
                    try_next = try_reg + TRY_W'(1);
                end
                state_next = RANGE;
            end
            RANGE: begin
                if (cand_h_reg >= H_W'(H_LIMIT) || cand_v_reg >= V_W'(V_LIMIT)) begin
                    state_next = REJECT;
                end else if (len_reg == '0) begin
                    state_next = COMMIT;
                end else begin
                    idx_next   = '0;
                    state_next = READ;
                end
            end
            // Segment store has a registered read port: data lands one cycle later.
            READ: begin
                state_next = CMP;
            end
            CMP: begin
                if (SEG_H == cand_h_reg && SEG_V == cand_v_reg) begin
                    state_next = REJECT;
                end else if ({1'b0, idx_reg} == len_reg - LEN_W'(1)) begin
                    state_next = COMMIT;
                end else begin
                    idx_next   = idx_reg + SEG_IDX_W'(1);
                    state_next = READ;
                end
            end
            REJECT: begin
                if (try_reg < TRY_W'(MAX_TRIES)) begin
                    state_next = SAMPLE;
                end else begin
                    // Out of tries: fall back to screen centre without an occupancy check.
                    cand_h_next = H_W'(H_DEFAULT);
                    cand_v_next = V_W'(V_DEFAULT);
                    state_next  = COMMIT;
                end
            end
            COMMIT: begin
                tgt_h_next = cand_h_reg;
                tgt_v_next = cand_v_reg;
                valid_next = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign SEG_RD_ADDR   = idx_reg;
    assign TARGET_ADDR_H = tgt_h_reg;
    assign TARGET_ADDR_V = tgt_v_reg;
    assign TARGET_VALID  = valid_reg;
    assign BUSY          = (state_reg != IDLE);
    assign PLACED        = (state_reg == COMMIT);

endmodule
